// File: rtl/mc_pkg.sv
// mc_pkg: sequencer state codes, opcodes, IR field positions and immediate sign-extension helpers
package mc_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_LW  = 2'd1;
  localparam logic [1:0] OP_SW  = 2'd2;
  localparam logic [1:0] OP_JMP = 2'd3;
  localparam int OP_LSB = 6;
  localparam int RS_LSB = 4;
  localparam int RT_LSB = 2;
  localparam int RD_LSB = 0;
  function automatic logic [7:0] sext2(input logic [1:0] v);
    return {{6{v[1]}}, v};
  endfunction
  function automatic logic [7:0] sext6(input logic [5:0] v);
    return {{2{v[5]}}, v};
  endfunction
endpackage

// File: rtl/mc_pc_unit.sv
// mc_pc_unit: PC register with increment, relative jump and RESET_PC load (in: clk Reset inc jmp off; out: pc)
module mc_pc_unit
  import mc_pkg::*;
#(
  parameter int PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                inc,
  input  logic                jmp,
  input  logic [5:0]          off,
  output logic [PC_WIDTH-1:0] pc
);
  logic [PC_WIDTH-1:0] pc1;
  assign pc1 = pc + PC_WIDTH'(1);
  always_ff @(posedge clk or posedge Reset)
    if (Reset) pc <= RESET_PC;
    else if (jmp) pc <= pc1 + PC_WIDTH'($signed(sext6(off)));
    else if (inc) pc <= pc1;
endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control (in: clk Reset Instruction imem_ready dmem_ready run step; out: ReadAddress imem_req ir fields imm_ext strobes state retired)
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [7:0]           Instruction,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 run,
  input  logic                 step,
  output logic [PC_WIDTH-1:0]  ReadAddress,
  output logic                 imem_req,
  output logic [7:0]           ir,
  output logic [1:0]           rs_addr,
  output logic [1:0]           rt_addr,
  output logic [1:0]           rd_addr,
  output logic [7:0]           imm_ext,
  output logic                 alu_en,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] retired
);
  state_t st, nx;
  logic step_q, go, retire;
  logic [1:0] op;
  assign op = ir[OP_LSB +: 2];
  assign go = run | (step & ~step_q);
  assign rs_addr = ir[RS_LSB +: 2];
  assign rt_addr = ir[RT_LSB +: 2];
  assign rd_addr = ir[RD_LSB +: 2];
  assign imm_ext = sext2(ir[RD_LSB +: 2]);
  assign state = st;
  assign imem_req = st == S_FETCH;
  assign alu_en = st == S_EXEC;
  assign mem_read = st == S_MEM && op == OP_LW;
  assign mem_write = st == S_MEM && op == OP_SW;
  assign reg_write = st == S_WB;
  assign mem_to_reg = st == S_WB && op == OP_LW;
  assign retire = (st == S_DECODE && op == OP_JMP) || (st == S_MEM && dmem_ready && op == OP_SW) || st == S_WB;
  always_comb begin
    nx = S_IDLE;
    case (st)
      S_IDLE:   nx = go ? S_FETCH : S_IDLE;
      S_FETCH:  nx = imem_ready ? S_DECODE : S_FETCH;
      S_DECODE: nx = S_EXEC;
      S_EXEC:   nx = op == OP_ADD ? S_WB : S_MEM;
      S_MEM:    nx = dmem_ready ? S_WB : S_MEM;
      default:  nx = S_IDLE;
    endcase
    if (retire) nx = run ? S_FETCH : S_IDLE;
  end
  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      st <= S_IDLE;
      ir <= '0;
      retired <= '0;
      step_q <= 1'b0;
    end else begin
      st <= nx;
      step_q <= step;
      if (st == S_FETCH && imem_ready) ir <= Instruction;
      if (retire) retired <= retired + CNT_WIDTH'(1);
    end
  mc_pc_unit #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .Reset(Reset),
    .inc(retire && op != OP_JMP),
    .jmp(retire && op == OP_JMP),
    .off(ir[5:0]),
    .pc(ReadAddress)
  );
endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: scoreboard bench for mc_sequencer retire order, state walk, strobes, step mode, async reset and wrap
module tb_mc_sequencer;
  logic clk = 1'b0, Reset = 1'b1, imem_ready = 1'b1, dmem_ready = 1'b1, run = 1'b0, step = 1'b0;
  logic [7:0] Instruction, ReadAddress, ir, imm_ext;
  logic [1:0] rs_addr, rt_addr, rd_addr;
  logic imem_req, alu_en, mem_read, mem_write, reg_write, mem_to_reg;
  logic [2:0] state;
  logic [15:0] retired;
  logic [7:0] imem [256];
  typedef struct packed {logic [7:0] pc; logic [15:0] ret;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [7:0] m_pc = 8'h00;
  logic [15:0] m_ret = 16'd0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  assign Instruction = imem[ReadAddress];
  mc_sequencer dut (
    .clk(clk), .Reset(Reset), .Instruction(Instruction), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .run(run), .step(step), .ReadAddress(ReadAddress),
    .imem_req(imem_req), .ir(ir), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .imm_ext(imm_ext), .alu_en(alu_en), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .state(state), .retired(retired)
  );
  task automatic push_instr(input logic [7:0] ins);
    imem[m_pc] = ins;
    m_pc = ins[7:6] == 2'b11 ? m_pc + 8'd1 + {{2{ins[5]}}, ins[5:0]} : m_pc + 8'd1;
    m_ret = m_ret + 16'd1;
    q.push_back({m_pc, m_ret});
  endtask
  task automatic wait_retire(output bit hit, output int cyc);
    logic [15:0] r0;
    r0 = retired;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < 40) begin
      @(negedge clk);
      cyc++;
      hit = retired !== r0;
    end
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++;
    if ({state, ReadAddress, ir, retired} !== 35'd0) begin
      fails++;
      $display("FAIL reset_regs: state=%0d pc=%h ir=%h ret=%0d, want all zero", state, ReadAddress, ir, retired);
    end
    tests++;
    if ({imem_req, alu_en, mem_read, mem_write, reg_write, mem_to_reg} !== 6'b0) begin
      fails++;
      $display("FAIL reset_strobes: got %b, want 000000", {imem_req, alu_en, mem_read, mem_write, reg_write, mem_to_reg});
    end
  endtask
  task automatic test_add;
    logic [2:0] seq [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    bit hit;
    int c;
    push_instr(8'h06);
    push_instr(8'h00);
    run = 1'b1;
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (state !== seq[i]) begin
        fails++;
        $display("FAIL add_state[%0d]: got %0d, want %0d", i, state, seq[i]);
      end
      if (i == 0) begin
        tests++;
        if (ReadAddress !== 8'h00 || imem_req !== 1'b1) begin
          fails++;
          $display("FAIL add_fetch: pc=%h req=%b, want 00 1", ReadAddress, imem_req);
        end
      end
      if (i == 2) begin
        tests++;
        if (alu_en !== 1'b1 || rd_addr !== 2'd2 || reg_write !== 1'b0) begin
          fails++;
          $display("FAIL add_exec: alu_en=%b rd=%0d reg_write=%b, want 1 2 0", alu_en, rd_addr, reg_write);
        end
      end
      if (i == 3) begin
        tests++;
        if ({reg_write, mem_to_reg, alu_en} !== 3'b100) begin
          fails++;
          $display("FAIL add_wb: got %b, want 100", {reg_write, mem_to_reg, alu_en});
        end
      end
    end
    e = q.pop_front();
    tests++;
    if (ReadAddress !== e.pc || retired !== e.ret) begin
      fails++;
      $display("FAIL add_retire: pc=%h ret=%0d, want pc=%h ret=%0d", ReadAddress, retired, e.pc, e.ret);
    end
    run = 1'b0;
    wait_retire(hit, c);
    e = q.pop_front();
    tests++;
    if (!hit || ReadAddress !== e.pc || retired !== e.ret || state !== 3'd0) begin
      fails++;
      $display("FAIL run_drop: hit=%b pc=%h ret=%0d st=%0d, want pc=%h ret=%0d st=0", hit, ReadAddress, retired, state, e.pc, e.ret);
    end
  endtask
  task automatic test_lw;
    push_instr(8'h53);
    dmem_ready = 1'b0;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    tests++;
    if (state !== 3'd2 || imm_ext !== 8'hFF || rs_addr !== 2'd1 || rt_addr !== 2'd0) begin
      fails++;
      $display("FAIL lw_decode: st=%0d imm=%h rs=%0d rt=%0d, want 2 FF 1 0", state, imm_ext, rs_addr, rt_addr);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (state !== 3'd4 || mem_read !== 1'b1 || mem_write !== 1'b0 || alu_en !== 1'b0) begin
        fails++;
        $display("FAIL lw_mem[%0d]: st=%0d rd=%b wr=%b alu=%b, want 4 1 0 0", i, state, mem_read, mem_write, alu_en);
      end
      if (i == 3) dmem_ready = 1'b1;
    end
    @(negedge clk);
    tests++;
    if (state !== 3'd5 || {reg_write, mem_to_reg, mem_read} !== 3'b110) begin
      fails++;
      $display("FAIL lw_wb: st=%0d strobes=%b, want 5 110", state, {reg_write, mem_to_reg, mem_read});
    end
    @(negedge clk);
    e = q.pop_front();
    tests++;
    if (ReadAddress !== e.pc || retired !== e.ret || state !== 3'd0) begin
      fails++;
      $display("FAIL lw_retire: pc=%h ret=%0d st=%0d, want pc=%h ret=%0d st=0", ReadAddress, retired, state, e.pc, e.ret);
    end
  endtask
  task automatic test_jump;
    bit hit;
    int c;
    push_instr(8'h00);
    push_instr(8'h00);
    push_instr(8'hFE);
    run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_retire(hit, c);
      e = q.pop_front();
      tests++;
      if (!hit || ReadAddress !== e.pc || retired !== e.ret) begin
        fails++;
        $display("FAIL jmp_pre[%0d]: hit=%b pc=%h ret=%0d, want pc=%h ret=%0d", i, hit, ReadAddress, retired, e.pc, e.ret);
      end
    end
    run = 1'b0;
    @(negedge clk);
    tests++;
    if (state !== 3'd2 || ir !== 8'hFE || {alu_en, mem_read, mem_write, reg_write, mem_to_reg} !== 5'b0) begin
      fails++;
      $display("FAIL jmp_decode: st=%0d ir=%h strobes=%b, want 2 FE 00000", state, ir, {alu_en, mem_read, mem_write, reg_write, mem_to_reg});
    end
    @(negedge clk);
    e = q.pop_front();
    tests++;
    if (ReadAddress !== e.pc || ReadAddress !== 8'h04 || retired !== e.ret || state !== 3'd0) begin
      fails++;
      $display("FAIL jmp_retire: pc=%h ret=%0d st=%0d, want pc=%h(04) ret=%0d st=0", ReadAddress, retired, state, e.pc, e.ret);
    end
  endtask
  task automatic test_step;
    bit hit;
    int c;
    push_instr(8'h06);
    push_instr(8'h06);
    step = 1'b1;
    @(negedge clk);
    tests++;
    if (state !== 3'd1) begin
      fails++;
      $display("FAIL step1_start: st=%0d, want 1", state);
    end
    repeat (2) @(negedge clk);
    step = 1'b0;
    wait_retire(hit, c);
    e = q.pop_front();
    tests++;
    if (!hit || ReadAddress !== e.pc || retired !== e.ret || state !== 3'd0) begin
      fails++;
      $display("FAIL step1_retire: hit=%b pc=%h ret=%0d st=%0d, want pc=%h ret=%0d st=0", hit, ReadAddress, retired, state, e.pc, e.ret);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (state !== 3'd0 || retired !== e.ret) begin
      fails++;
      $display("FAIL step_idle_hold: st=%0d ret=%0d, want 0 %0d", state, retired, e.ret);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (state !== 3'd3) begin
      fails++;
      $display("FAIL step2_exec: st=%0d, want 3", state);
    end
    step = 1'b1;
    @(negedge clk);
    @(negedge clk);
    e = q.pop_front();
    tests++;
    if (ReadAddress !== e.pc || retired !== e.ret || state !== 3'd0) begin
      fails++;
      $display("FAIL step2_retire: pc=%h ret=%0d st=%0d, want pc=%h ret=%0d st=0", ReadAddress, retired, state, e.pc, e.ret);
    end
    repeat (2) @(negedge clk);
    step = 1'b0;
    tests++;
    if (state !== 3'd0 || retired !== m_ret || q.size() != 0) begin
      fails++;
      $display("FAIL step_no_retrigger: st=%0d ret=%0d pending=%0d, want 0 %0d 0", state, retired, q.size(), m_ret);
    end
  endtask
  task automatic test_async_reset;
    imem[m_pc] = 8'h84;
    dmem_ready = 1'b0;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (state !== 3'd4 || mem_write !== 1'b1 || mem_read !== 1'b0) begin
      fails++;
      $display("FAIL sw_mem: st=%0d wr=%b rd=%b, want 4 1 0", state, mem_write, mem_read);
    end
    #2 Reset = 1'b1;
    #1;
    tests++;
    if (mem_write !== 1'b0 || state !== 3'd0 || ReadAddress !== 8'h00 || retired !== 16'd0) begin
      fails++;
      $display("FAIL async_reset: wr=%b st=%0d pc=%h ret=%0d, want 0 0 00 0", mem_write, state, ReadAddress, retired);
    end
    m_pc = 8'h00;
    m_ret = 16'd0;
    q.delete();
    @(negedge clk);
    dmem_ready = 1'b1;
    Reset = 1'b0;
    @(negedge clk);
    tests++;
    if (state !== 3'd0 || ir !== 8'h00) begin
      fails++;
      $display("FAIL post_reset_idle: st=%0d ir=%h, want 0 00", state, ir);
    end
  endtask
  task automatic test_wrap;
    logic [7:0] prog [4] = '{8'hFE, 8'h00, 8'hFD, 8'hDF};
    logic [7:0] want [4] = '{8'hFF, 8'h00, 8'hFE, 8'h1E};
    bit hit;
    int c;
    for (int i = 0; i < 4; i++) begin
      push_instr(prog[i]);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      wait_retire(hit, c);
      e = q.pop_front();
      tests++;
      if (!hit || ReadAddress !== e.pc || ReadAddress !== want[i] || retired !== e.ret) begin
        fails++;
        $display("FAIL wrap[%0d]: hit=%b pc=%h ret=%0d, want pc=%h ret=%0d", i, hit, ReadAddress, retired, want[i], e.ret);
      end
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] prog [4] = '{8'h06, 8'h53, 8'h84, 8'hC0};
    int lat [4] = '{5, 5, 4, 2};
    bit hit;
    int c;
    for (int i = 0; i < 4; i++) push_instr(prog[i]);
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_retire(hit, c);
      if (i == 2) run = 1'b0;
      e = q.pop_front();
      tests++;
      if (!hit || c != lat[i] || ReadAddress !== e.pc || retired !== e.ret) begin
        fails++;
        $display("FAIL b2b[%0d]: hit=%b cyc=%0d pc=%h ret=%0d, want cyc=%0d pc=%h ret=%0d", i, hit, c, ReadAddress, retired, lat[i], e.pc, e.ret);
      end
    end
    @(negedge clk);
    tests++;
    if (state !== 3'd0 || retired !== 16'd8) begin
      fails++;
      $display("FAIL b2b_end: st=%0d ret=%0d, want 0 8", state, retired);
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    test_reset;
    test_add;
    test_lw;
    test_jump;
    test_step;
    test_async_reset;
    test_wrap;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
Multi-cycle control sequencer for the 8-bit microprocessor datapath (4-register file, adder ALU, data memory, 7-segment output).
- Owns the PC and the instruction register (IR).
- Fetches 8-bit instructions over a ready handshake and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath strobes.
- Supports free-run and single-step modes for board debugging.

Parameters:
PC_WIDTH, 8, width of PC / ReadAddress
RESET_PC, 8'h00, PC value loaded on Reset
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Instruction  in  8  instruction word for current ReadAddress
imem_ready  in  1  Instruction valid this cycle
dmem_ready  in  1  data memory completed current read/write
run  in  1  1 = free-run; 0 = single-step
step  in  1  single-step request (level; edge-detected internally)
ReadAddress  out  PC_WIDTH  current PC
imem_req  out  1  fetch request
ir  out  8  latched instruction
rs_addr, rt_addr, rd_addr  out  2 each  ir[5:4], ir[3:2], ir[1:0]
imm_ext  out  8  sign-extended ir[1:0]
alu_en, mem_read, mem_write, reg_write, mem_to_reg  out  1 each  datapath strobes
state  out  3  current FSM state
retired  out  CNT_WIDTH  retired-instruction count

Behaviour:
- ISA: op = ir[7:6]. 00 = add (rd <= rs + rt). 01 = lw (rt <= mem[rs + sext(imm)]). 10 = sw (mem[rs + sext(imm)] <= rt). 11 = jump (PC <= PC + 1 + sext(ir[5:0])).
- Reset (async, any time, including mid-instruction):
  - state = IDLE, PC = RESET_PC, ir = 0, retired = 0, step_q = 0.
  - All strobes and imem_req = 0.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5; codes 6-7 illegal, go to IDLE.
- IDLE: exits to FETCH if run=1, or on a step rising edge (step & ~step_q). Otherwise holds. step_q updates every cycle.
- FETCH:
  - imem_req=1, ReadAddress=PC.
  - On imem_ready: ir <= Instruction, go to DECODE. Otherwise holds; wait is unbounded.
- DECODE:
  - jump: retires here (PC update per ISA).
  - all other ops: go to EXEC.
- EXEC: alu_en=1 for exactly 1 cycle. add goes to WB; lw/sw go to MEM.
- MEM:
  - lw asserts mem_read; sw asserts mem_write. Held until dmem_ready.
  - On dmem_ready: lw goes to WB; sw retires.
- WB: reg_write=1 for 1 cycle; mem_to_reg=1 iff lw. Then retires.
- Retire (same edge as the exit transition):
  - PC <= PC+1 for non-jump ops.
  - retired <= retired+1.
  - Next state is FETCH if run=1, else IDLE.
- Arithmetic: PC and jump target wrap modulo 2^PC_WIDTH; retired wraps.
- Strobe decoding: strobes are decoded combinationally from state and ir only. No strobe is ever asserted in IDLE, FETCH or DECODE.
- Minimum latency (zero wait states): add 4 cycles, lw 5, sw 4, jump 2.
- Mode changes and step timing:
  - run dropped mid-instruction: the instruction completes, then IDLE.
  - step edge while not in IDLE: ignored, not queued.
- ReadAddress equals PC in every state; it is stable throughout FETCH.

Decomposition:
- Shared package mc_pkg:
  - state encodings;
  - opcode constants OP_ADD/OP_LW/OP_SW/OP_JMP;
  - field position constants;
  - the sext2/sext6 functions.
- One sub-module mc_pc_unit: PC register, increment, jump-target adder, wrap logic, RESET_PC load.
- The FSM, IR, step edge detector and counter stay in mc_sequencer.

Test Plan:
1. Reset=1, then 0; run=1; imem_ready=1; Instruction=8'h06 (add r2=r0+r1).
   -> ReadAddress 00. State sequence 1,2,3,5,1. alu_en high in EXEC, reg_write high in WB, rd_addr=2. PC=01, retired=1 after 4 cycles.
2. Instruction=8'h53 (lw rt=0, rs=1, imm=-1); dmem_ready held 0 for 3 cycles.
   -> imm_ext=8'hFF. mem_read high for 4 cycles (MEM with 3 wait cycles). WB has mem_to_reg=1, reg_write=1. Total 8 cycles.
3. PC=8'h05, Instruction=8'hFE (jump -2).
   -> Retires in DECODE, PC=8'h04. No strobe asserted. retired +1.
4. run=0; step pulsed twice (3 cycles high each, 2 instructions apart); Instruction=8'h06.
   -> Exactly 2 instructions retire. Holding step high does not re-trigger. A step edge during EXEC is ignored.
5. Reset asserted asynchronously in MEM with mem_write=1 (sw 8'h84).
   -> mem_write, state, PC and retired clear immediately, without waiting for a clock edge.
6. PC=8'hFF, add.
   -> PC wraps to 8'h00. Jump at PC=8'hFE with +31 (8'hDF) -> PC=8'h1E.
